zero_insert_window_h_fp16: RTL and testbench

ZERO_INSERT_WINDOW_H_FP16 -- requirements
Module: zero_insert_window_h_fp16

---
 rtl/zero_insert_window_h_fp16_if.sv | 25 ++
 rtl/zero_insert_window_h_fp16.sv | 172 +++++++++++++++++
 tb/tb_zero_insert_window_h_fp16.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zero_insert_window_h_fp16_if.sv
// Sample-in / window-out bundle for the horizontal zero-insert window block.
// The block drives the *_o members; its source and sink drive and read the *_i members.
interface zero_insert_window_h_fp16_if #(
   parameter int FP_WIDTH_REG = 16
);
   logic [FP_WIDTH_REG-1:0] pixel_i;
   logic [15:0]             col_i;
   logic [15:0]             row_i;
   logic                    valid_i;
   logic                    ready_o;
   logic [FP_WIDTH_REG-1:0] window_o [1][5];
   logic [15:0]             col_o;
   logic [15:0]             row_o;
   logic                    valid_o;

   modport slave (
      input  pixel_i, col_i, row_i, valid_i,
      output ready_o, window_o, col_o, row_o, valid_o
   );

   modport master (
      output pixel_i, col_i, row_i, valid_i,
      input  ready_o, window_o, col_o, row_o, valid_o
   );
endinterface

// File: rtl/zero_insert_window_h_fp16.sv
// Horizontal 2x zero-insert with a 1x5 sliding window over the expanded row.
// Optional ZIW_ERROR_DETECT_EN adds a sticky error_o for handshake/column-order violations.
//
// state    | meaning
// S_PIX    | waiting for an input pixel; only state with ready_o high
// S_ZERO   | pushing the inserted +0.0 that follows the last accepted pixel
// S_FLUSH0 | end of row: pushing padding zero for center 2*IMG_WIDTH-2
// S_FLUSH1 | end of row: pushing padding zero for center 2*IMG_WIDTH-1
module zero_insert_window_h_fp16 #(
   parameter int EXP_WIDTH    = 5,
   parameter int FRAC_WIDTH   = 10,
   parameter int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH,
   parameter int IMG_WIDTH    = 640
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   zero_insert_window_h_fp16_if.slave  bus
`ifdef ZIW_ERROR_DETECT_EN
   ,
   output logic                        error_o
`endif
);

   typedef enum logic [1:0] {
      S_PIX    = 2'd0,
      S_ZERO   = 2'd1,
      S_FLUSH0 = 2'd2,
      S_FLUSH1 = 2'd3
   } state_t;

   localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
   localparam logic [15:0] K_FLUSH0 = 16'(2 * IMG_WIDTH - 2);
   localparam logic [15:0] K_FLUSH1 = 16'(2 * IMG_WIDTH - 1);

   state_t                  state_q, state_d;
   logic [FP_WIDTH_REG-1:0] sr_q [5];
   logic [15:0]             col_q, col_d;
   logic [15:0]             row_q, row_d;
   logic                    valid_q, valid_d;
   logic [15:0]             col_out_q, col_out_d;
   logic [15:0]             row_out_q, row_out_d;

   logic                    ready;
   logic                    xfer;
   logic                    push;
   logic                    clear;
   logic [FP_WIDTH_REG-1:0] push_data;

   assign ready = (state_q == S_PIX);
   assign xfer  = ready && bus.valid_i;

   // Center index k trails the pushed expanded index j by two; a window is
   // only emitted once k is non-negative, i.e. from the second pixel onward.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      valid_d   = 1'b0;
      col_out_d = col_out_q;
      row_out_d = row_out_q;
      push      = 1'b0;
      clear     = 1'b0;
      push_data = '0;
      unique case (state_q)
         S_PIX: begin
            if (xfer) begin
               push      = 1'b1;
               clear     = (bus.col_i == 16'd0);
               push_data = bus.pixel_i;
               col_d     = bus.col_i;
               row_d     = bus.row_i;
               state_d   = S_ZERO;
               if (bus.col_i != 16'd0) begin
                  valid_d   = 1'b1;
                  col_out_d = {bus.col_i[14:0], 1'b0} - 16'd2;
                  row_out_d = bus.row_i;
               end
            end
         end
         S_ZERO: begin
            push    = 1'b1;
            state_d = (col_q == LAST_COL) ? S_FLUSH0 : S_PIX;
            if (col_q != 16'd0) begin
               valid_d   = 1'b1;
               col_out_d = {col_q[14:0], 1'b0} - 16'd1;
               row_out_d = row_q;
            end
         end
         S_FLUSH0: begin
            push      = 1'b1;
            state_d   = S_FLUSH1;
            valid_d   = 1'b1;
            col_out_d = K_FLUSH0;
            row_out_d = row_q;
         end
         S_FLUSH1: begin
            push      = 1'b1;
            state_d   = S_PIX;
            valid_d   = 1'b1;
            col_out_d = K_FLUSH1;
            row_out_d = row_q;
         end
         default: begin
            state_d = S_PIX;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_PIX;
         col_q     <= '0;
         row_q     <= '0;
         valid_q   <= 1'b0;
         col_out_q <= '0;
         row_out_q <= '0;
         for (int i = 0; i < 5; i++) begin
            sr_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         valid_q   <= valid_d;
         col_out_q <= col_out_d;
         row_out_q <= row_out_d;
         if (push) begin
            // A column-0 pixel starts a fresh row, so older taps become +0.0.
            for (int i = 0; i < 4; i++) begin
               sr_q[i] <= clear ? '0 : sr_q[i+1];
            end
            sr_q[4] <= push_data;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         bus.window_o[0][i] = sr_q[i];
      end
   end

   assign bus.ready_o = ready;
   assign bus.valid_o = valid_q;
   assign bus.col_o   = col_out_q;
   assign bus.row_o   = row_out_q;

`ifdef ZIW_ERROR_DETECT_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (bus.valid_i && !ready) begin
         err_d = 1'b1;
      end
      if (xfer && (bus.col_i != 16'd0) && (bus.col_i != col_q + 16'd1)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign error_o = err_q;
`endif

endmodule

// File: tb/tb_zero_insert_window_h_fp16.sv
// Randomized bench for zero_insert_window_h_fp16 (IMG_WIDTH=4) against a positional row model.
// Define ZIW_ERROR_DETECT_EN to also exercise error_o.
module tb_zero_insert_window_h_fp16;

   localparam int W = 4;
   localparam logic [15:0] PA = 16'h3C00;
   localparam logic [15:0] PB = 16'h4000;
   localparam logic [15:0] PC = 16'h4200;
   localparam logic [15:0] PD = 16'h4400;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef ZIW_ERROR_DETECT_EN
   logic error_o;
`endif

   always #5 clk = ~clk;

   zero_insert_window_h_fp16_if #(.FP_WIDTH_REG(16)) bus ();

   zero_insert_window_h_fp16 #(
      .EXP_WIDTH (5),
      .FRAC_WIDTH(10),
      .IMG_WIDTH (W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
`ifdef ZIW_ERROR_DETECT_EN
      ,
      .error_o(error_o)
`endif
   );

   typedef struct {
      int          cyc;
      logic [15:0] k;
      logic [15:0] row;
      logic [79:0] win;
   } ev_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          busy_until = 0;
   bit          armed = 0;
   bit          model_on = 1;
   int          cur_col = 0;
   int          cur_row = 0;
   logic [15:0] arr [W];
   ev_t         evq [$];
   logic [79:0] obs_win [2*W];
   logic [15:0] last_row;
   logic [9:0]  rdy_log;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expanded row: even slots carry the pixel of column j/2, odd and out-of-row slots are +0.0.
   function automatic logic [15:0] ex(input int j);
      if (j < 0 || j >= 2 * W || (j % 2) != 0) return 16'h0000;
      return arr[j/2];
   endfunction

   function automatic logic [79:0] win_at(input int k);
      return {ex(k-2), ex(k-1), ex(k), ex(k+1), ex(k+2)};
   endfunction

   function automatic logic [79:0] pack5(input logic [15:0] a, b, c, d, e);
      return {a, b, c, d, e};
   endfunction

   function automatic logic [79:0] dut_win();
      return {bus.window_o[0][0], bus.window_o[0][1], bus.window_o[0][2],
              bus.window_o[0][3], bus.window_o[0][4]};
   endfunction

   task automatic add_ev(input int c, input int k, input int r);
      ev_t ev;
      ev.cyc = c;
      ev.k   = 16'(k);
      ev.row = 16'(r);
      ev.win = win_at(k);
      evq.push_back(ev);
   endtask

   task automatic check_out();
      logic [79:0] obs;
      obs = dut_win();
      if (bus.valid_o === 1'b1) begin
         if (bus.col_o < 16'(2 * W)) obs_win[bus.col_o[2:0]] = obs;
         last_row = bus.row_o;
      end
      if (!armed || !model_on) return;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
         chk("valid", 80'(bus.valid_o), 80'(1'b1));
         chk("col", 80'(bus.col_o), 80'(evq[0].k));
         chk("row", 80'(bus.row_o), 80'(evq[0].row));
         chk("window", obs, evq[0].win);
         void'(evq.pop_front());
      end else begin
         chk("idle_valid", 80'(bus.valid_o), 80'(1'b0));
      end
   endtask

   // One clock: called at a negedge, drives inputs, advances model at posedge, checks at next negedge.
   task automatic cycle(input bit v, input logic [15:0] px, input bit rs);
      bit xfer;
      if (armed) chk("ready", 80'(bus.ready_o), 80'(cyc >= busy_until));
      rdy_log = {rdy_log[8:0], bus.ready_o};
      xfer = v && !rs && armed && (cyc >= busy_until);
      rst         = rs;
      bus.valid_i = v;
      bus.pixel_i = px;
      bus.col_i   = 16'(cur_col);
      bus.row_i   = 16'(cur_row);
      @(posedge clk);
      cyc++;
      if (rs) begin
         evq.delete();
         busy_until = cyc;
         foreach (arr[i]) arr[i] = 16'h0000;
         cur_col = 0;
         armed = 1;
      end else if (xfer) begin
         if (cur_col == 0) foreach (arr[i]) arr[i] = 16'h0000;
         arr[cur_col] = px;
         if (cur_col > 0) begin
            add_ev(cyc, 2 * cur_col - 2, cur_row);
            add_ev(cyc + 1, 2 * cur_col - 1, cur_row);
         end
         if (cur_col == W - 1) begin
            add_ev(cyc + 2, 2 * W - 2, cur_row);
            add_ev(cyc + 3, 2 * W - 1, cur_row);
            busy_until = cyc + 3;
            cur_col = 0;
            cur_row++;
         end else begin
            busy_until = cyc + 1;
            cur_col++;
         end
      end
      @(negedge clk);
      check_out();
   endtask

   task automatic run_held(input logic [15:0] p0, p1, p2, p3, input int n);
      logic [15:0] px [4];
      px = '{p0, p1, p2, p3};
      repeat (n) cycle(1'b1, px[cur_col], 1'b0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_window"}, dut_win(), 80'h0);
      chk({tag, "_col"}, 80'(bus.col_o), 80'h0);
      chk({tag, "_row"}, 80'(bus.row_o), 80'h0);
      chk({tag, "_valid"}, 80'(bus.valid_o), 80'h0);
   endtask

   task automatic clear_obs();
      foreach (obs_win[i]) obs_win[i] = '1;
      last_row = 16'hFFFF;
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.pixel_i = '0;
      bus.col_i   = '0;
      bus.row_i   = '0;
      rdy_log     = '0;
      foreach (arr[i]) arr[i] = 16'h0000;
      @(negedge clk);
      repeat (3) cycle(1'b0, 16'h0, 1'b1);
      reset_checks("reset");

      // Full row, valid held high
      cur_col = 0; cur_row = 0; rdy_log = '0; clear_obs();
      run_held(PA, PB, PC, PD, 10);
      chk("ready_pattern", 80'(rdy_log), 80'(10'b1010101000));
      chk("k0_window", obs_win[0], pack5(16'h0, 16'h0, PA, 16'h0, PB));
      chk("k2_window", obs_win[2], pack5(PA, 16'h0, PB, 16'h0, PC));
      chk("k7_window", obs_win[7], pack5(16'h0, PD, 16'h0, 16'h0, 16'h0));
      chk("row0", 80'(last_row), 80'h0);

      // Restart at column 0 mid-row abandons the partial row
      cur_col = 0; cur_row = 0;
      run_held(PA, PB, PC, PD, 4);
      cur_col = 0; cur_row = 1; clear_obs();
      run_held(PC, PD, PA, PB, 10);
      chk("restart_k0", obs_win[0], pack5(16'h0, 16'h0, PC, 16'h0, PD));
      chk("restart_row", 80'(last_row), 80'h1);

      // Reset mid-row
      cur_col = 0; cur_row = 2;
      run_held(PA, PB, PC, PD, 5);
      cycle(1'b0, 16'h0, 1'b1);
      reset_checks("midrow_reset");
      cur_col = 0; cur_row = 3; clear_obs();
      run_held(PD, PC, PB, PA, 10);
      chk("post_reset_k0", obs_win[0], pack5(16'h0, 16'h0, PD, 16'h0, PC));

      // Randomized traffic with occasional restarts and resets
      for (int n = 0; n < 3000; n++) begin
         bit rs;
         rs = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 39) == 0 && cur_col != 0) begin
            cur_col = 0;
            cur_row++;
         end
         cycle(($urandom_range(0, 3) != 0), 16'($urandom), rs);
      end
      repeat (6) cycle(1'b0, 16'h0, 1'b0);

`ifdef ZIW_ERROR_DETECT_EN
      model_on = 0;
      cycle(1'b0, 16'h0, 1'b1);
      chk("err_after_reset", 80'(error_o), 80'(1'b0));
      cur_col = 0;
      cycle(1'b1, PA, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      chk("err_seq_ok", 80'(error_o), 80'(1'b0));
      cur_col = 2;
      cycle(1'b1, PB, 1'b0);
      chk("err_col_skip", 80'(error_o), 80'(1'b1));
      repeat (4) cycle(1'b0, 16'h0, 1'b0);
      chk("err_sticky", 80'(error_o), 80'(1'b1));
      cycle(1'b0, 16'h0, 1'b1);
      chk("err_cleared", 80'(error_o), 80'(1'b0));
      cur_col = 0;
      cycle(1'b1, PA, 1'b0);
      cycle(1'b1, PB, 1'b0);
      chk("err_not_ready", 80'(error_o), 80'(1'b1));
      cycle(1'b0, 16'h0, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
